// File: rtl/mux_arb_rr.sv
// mux_arb_rr: parametrised N-to-1 multiplexer with valid/ready handshakes
// and a registered output stage.
//
// A runtime mode picks the granted channel:
//   manual (sel), fixed priority (lowest index wins), or round-robin.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    packed channel data, channel i at [i*ANCHO +: ANCHO]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (combinational)
//   modo       00 manual, 01 fixed priority, 10/11 round-robin
//   sel        manual-mode channel index
//   out_data   registered output word
//   out_canal  index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  downstream accept
module mux_arb_rr #(
   parameter  int ANCHO   = 8,
   parameter  int CANALES = 4,
   localparam int SEL_W   = $clog2(CANALES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CANALES*ANCHO-1:0]   in_data,
   input  logic [CANALES-1:0]         in_valid,
   output logic [CANALES-1:0]         in_ready,
   input  logic [1:0]                 modo,
   input  logic [SEL_W-1:0]           sel,
   output logic [ANCHO-1:0]           out_data,
   output logic [SEL_W-1:0]           out_canal,
   output logic                       out_valid,
   input  logic                       out_ready
);

   logic [ANCHO-1:0]   data_r;
   logic [SEL_W-1:0]   canal_r;
   logic               valid_r;
   logic [SEL_W-1:0]   ptr_r;

   logic [CANALES-1:0] grant_s;
   logic [SEL_W-1:0]   grant_idx_s;
   logic               grant_any_s;
   logic [SEL_W-1:0]   hi_idx_s;
   logic               hi_any_s;
   logic [SEL_W-1:0]   lo_idx_s;
   logic               lo_any_s;
   logic [ANCHO-1:0]   nxt_data_s;
   logic               load_en_s;
   logic               xfer_s;

   // The output register can accept a new word when empty or being drained.
   assign load_en_s = !valid_r | out_ready;
   assign xfer_s    = grant_any_s & load_en_s;

   // Round-robin search: lowest valid channel at or above ptr (hi), and
   // lowest valid channel overall (lo) used when the search wraps.
   always_comb begin
      hi_idx_s = '0;
      hi_any_s = 1'b0;
      lo_idx_s = '0;
      lo_any_s = 1'b0;
      // Descending scan so the last hit is the lowest index.
      for (int i = CANALES - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            lo_idx_s = SEL_W'(i);
            lo_any_s = 1'b1;
            if (SEL_W'(i) >= ptr_r) begin
               hi_idx_s = SEL_W'(i);
               hi_any_s = 1'b1;
            end else begin
               hi_idx_s = hi_idx_s;
            end
         end else begin
            lo_idx_s = lo_idx_s;
         end
      end
   end

   // Grant index selection per mode; grant implies the channel is valid.
   always_comb begin
      grant_idx_s = '0;
      grant_any_s = 1'b0;
      case (modo)
         2'b00: begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < CANALES; i++) begin
               if ((SEL_W'(i) == sel) && in_valid[i]) begin
                  grant_idx_s = SEL_W'(i);
                  grant_any_s = 1'b1;
               end else begin
                  grant_any_s = grant_any_s;
               end
            end
         end
         2'b01: begin
            grant_idx_s = lo_idx_s;
            grant_any_s = lo_any_s;
         end
         default: begin
            if (hi_any_s) begin
               grant_idx_s = hi_idx_s;
               grant_any_s = 1'b1;
            end else begin
               grant_idx_s = lo_idx_s;
               grant_any_s = lo_any_s;
            end
         end
      endcase
   end

   // One-hot grant vector and the granted channel's data word.
   always_comb begin
      grant_s    = '0;
      nxt_data_s = '0;
      for (int i = 0; i < CANALES; i++) begin
         if (grant_any_s && (grant_idx_s == SEL_W'(i))) begin
            grant_s[i] = 1'b1;
            nxt_data_s = in_data[i*ANCHO +: ANCHO];
         end else begin
            grant_s[i] = 1'b0;
         end
      end
   end

   assign in_ready = grant_s & {CANALES{load_en_s & !rst}};

   // Output register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r  <= '0;
         canal_r <= '0;
         valid_r <= 1'b0;
         ptr_r   <= '0;
      end else begin
         if (xfer_s) begin
            data_r  <= nxt_data_s;
            canal_r <= grant_idx_s;
            valid_r <= 1'b1;
         end else if (out_ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         // modo 10 and 11 are both round-robin.
         if (xfer_s && modo[1]) begin
            if (grant_idx_s == SEL_W'(CANALES - 1)) begin
               ptr_r <= '0;
            end else begin
               ptr_r <= grant_idx_s + SEL_W'(1);
            end
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   assign out_data  = data_r;
   assign out_canal = canal_r;
   assign out_valid = valid_r;

endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: directed self-checking bench for mux_arb_rr.
// u_dut uses the default 4 channels; u_dut5 uses 5 channels (SEL_W=3) so
// that an out-of-range manual select can be exercised.
module tb_mux_arb_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  modo;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_canal;
   logic        out_valid;
   logic        out_ready;

   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic [1:0]  modo5;
   logic [2:0]  sel5;
   logic [7:0]  out_data5;
   logic [2:0]  out_canal5;
   logic        out_valid5;
   logic        out_ready5;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   mux_arb_rr #(.ANCHO(8), .CANALES(4)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .modo(modo), .sel(sel), .out_data(out_data),
      .out_canal(out_canal), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_arb_rr #(.ANCHO(8), .CANALES(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
      .in_ready(in_ready5), .modo(modo5), .sel(sel5), .out_data(out_data5),
      .out_canal(out_canal5), .out_valid(out_valid5), .out_ready(out_ready5)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard bookkeeping for the cycle about to close, then advance.
   task automatic step();
      logic [7:0] w;
      if (out_valid && out_ready) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            w = sb.pop_front();
            chk("sb_word", 64'(out_data), 64'(w));
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (in_valid[i] && in_ready[i]) sb.push_back(in_data[i*8 +: 8]);
      end
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
      in_valid   = 4'hF;
      modo       = 2'b01;
      sel        = 2'd0;
      out_ready  = 1'b0;
      in_data5   = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
      in_valid5  = 5'h00;
      modo5      = 2'b00;
      sel5       = 3'd0;
      out_ready5 = 1'b0;
      tick();
      tick();

      // Reset state; in_ready held low by rst despite valid inputs.
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'h00);
      chk("rst_canal", 64'(out_canal), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      rst = 1'b0;

      // Round-robin from ptr=0: 0,1,2,3,0,1,2 back-to-back.
      modo      = 2'b10;
      out_ready = 1'b1;
      #1;
      chk("rr_first_ready", 64'(in_ready), 64'b0001);
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("rr_canal", 64'(out_canal), 64'(k % 4));
         chk("rr_data", 64'(out_data), 64'(8'h10 + 8'(k % 4)));
         chk("rr_valid", 64'(out_valid), 64'd1);
      end

      // ptr=3, only ch0/ch1 valid: wrap to ch0, then ch1.
      in_valid = 4'b0011;
      #1;
      chk("rr_wrap_ready", 64'(in_ready), 64'b0001);
      tick();
      chk("rr_wrap_canal", 64'(out_canal), 64'd0);
      #1;
      chk("rr_next_ready", 64'(in_ready), 64'b0010);
      tick();
      chk("rr_next_canal", 64'(out_canal), 64'd1);
      chk("rr_next_data", 64'(out_data), 64'h11);

      // Manual mode.
      modo     = 2'b00;
      sel      = 2'd1;
      in_valid = 4'hF;
      #1;
      chk("man_ready1", 64'(in_ready), 64'b0010);
      tick();
      chk("man_data1", 64'(out_data), 64'h11);
      chk("man_canal1", 64'(out_canal), 64'd1);
      sel = 2'd3;
      #1;
      chk("man_ready3", 64'(in_ready), 64'b1000);
      tick();
      chk("man_data3", 64'(out_data), 64'h13);
      chk("man_canal3", 64'(out_canal), 64'd3);

      // Fixed priority.
      modo     = 2'b01;
      in_valid = 4'b1100;
      #1;
      chk("fix_ready2", 64'(in_ready), 64'b0100);
      tick();
      chk("fix_data2", 64'(out_data), 64'h12);
      chk("fix_canal2", 64'(out_canal), 64'd2);
      in_valid = 4'b1000;
      #1;
      chk("fix_ready3", 64'(in_ready), 64'b1000);
      tick();
      chk("fix_data3", 64'(out_data), 64'h13);

      // ptr retained across mode changes (last RR grant was ch1 -> ptr=2).
      modo     = 2'b11;
      in_valid = 4'hF;
      #1;
      chk("rr_keep_ready", 64'(in_ready), 64'b0100);
      tick();
      chk("rr_keep_canal", 64'(out_canal), 64'd2);

      // Drain with nothing valid: output empties, data/canal hold.
      in_valid = 4'h0;
      #1;
      chk("idle_ready", 64'(in_ready), 64'h0);
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_data", 64'(out_data), 64'h12);
      chk("drain_canal", 64'(out_canal), 64'd2);

      // Backpressure, ptr=3: out_ready 1,0,0,1 then drain.
      modo      = 2'b10;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      #1;
      chk("bp_ready_a", 64'(in_ready), 64'b1000);
      step();
      chk("bp_data_a", 64'(out_data), 64'h13);
      out_ready = 1'b0;
      #1;
      chk("bp_ready_b", 64'(in_ready), 64'h0);
      step();
      chk("bp_hold_b", 64'(out_data), 64'h13);
      chk("bp_hold_canal_b", 64'(out_canal), 64'd3);
      #1;
      chk("bp_ready_c", 64'(in_ready), 64'h0);
      step();
      chk("bp_hold_c", 64'(out_data), 64'h13);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_d", 64'(in_ready), 64'b0001);
      step();
      chk("bp_data_d", 64'(out_data), 64'h10);
      in_valid = 4'h0;
      step();
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Reset mid-stall: load A5 from ch2, stall, assert rst between edges.
      in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
      modo     = 2'b00;
      sel      = 2'd2;
      in_valid = 4'b0100;
      tick();
      chk("stall_load", 64'(out_data), 64'hA5);
      out_ready = 1'b0;
      in_valid  = 4'h0;
      tick();
      chk("stall_hold", 64'(out_data), 64'hA5);
      in_valid = 4'hF;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'h00);
      chk("arst_canal", 64'(out_canal), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'h0);
      #1;
      rst = 1'b0;
      // ptr was 1 before reset; a ch0 grant shows it returned to 0.
      modo      = 2'b10;
      out_ready = 1'b1;
      #1;
      chk("arst_ptr_ready", 64'(in_ready), 64'b0001);
      tick();
      chk("arst_ptr_canal", 64'(out_canal), 64'd0);

      // Five channels: sel=5 is out of range and never transfers.
      in_valid5  = 5'h1F;
      modo5      = 2'b00;
      sel5       = 3'd5;
      out_ready5 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sel5_ready", 64'(in_ready5), 64'h0);
         tick();
         chk("sel5_valid", 64'(out_valid5), 64'd0);
      end
      sel5 = 3'd4;
      #1;
      chk("sel4_ready", 64'(in_ready5), 64'b10000);
      tick();
      chk("sel4_data", 64'(out_data5), 64'h24);
      chk("sel4_canal", 64'(out_canal5), 64'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
